// File: rtl/deque_stream_if.sv
// Bundle of every handshake and bus signal between the stream controller,
// its four upstream/downstream streams and the deque it drives.
//   fin_*  / bin_*  : front / back push streams (valid, ready, data)
//   fout_* / bout_* : front / back pop streams  (valid, ready, data)
//   dq_*            : push/pop strobes and push data to the deque,
//                     pop registers and occupancy back from it
// Modports: slave = controller view, master = environment (streams + deque).
interface deque_stream_if #(
  parameter int WORD_WIDTH = 32,
  parameter int ADDR_WIDTH = 6
);
  logic                  fin_valid, fin_ready;
  logic [WORD_WIDTH-1:0] fin_data;
  logic                  bin_valid, bin_ready;
  logic [WORD_WIDTH-1:0] bin_data;
  logic                  fout_valid, fout_ready;
  logic [WORD_WIDTH-1:0] fout_data;
  logic                  bout_valid, bout_ready;
  logic [WORD_WIDTH-1:0] bout_data;
  logic                  dq_front_push, dq_back_push, dq_front_pop, dq_back_pop;
  logic [WORD_WIDTH-1:0] dq_front_push_data, dq_back_push_data;
  logic [WORD_WIDTH-1:0] dq_front_pop_data, dq_back_pop_data;
  logic [ADDR_WIDTH:0]   dq_size;

  modport slave (
    input  fin_valid, fin_data, bin_valid, bin_data, fout_ready, bout_ready,
           dq_front_pop_data, dq_back_pop_data, dq_size,
    output fin_ready, bin_ready, fout_valid, fout_data, bout_valid, bout_data,
           dq_front_push, dq_back_push, dq_front_pop, dq_back_pop,
           dq_front_push_data, dq_back_push_data
  );

  modport master (
    output fin_valid, fin_data, bin_valid, bin_data, fout_ready, bout_ready,
           dq_front_pop_data, dq_back_pop_data, dq_size,
    input  fin_ready, bin_ready, fout_valid, fout_data, bout_valid, bout_data,
           dq_front_push, dq_back_push, dq_front_pop, dq_back_pop,
           dq_front_push_data, dq_back_push_data
  );
endinterface

// File: rtl/deque_stream_ctrl.sv
// Valid/ready front end for the deque. Turns two push streams and two pop
// streams into deque strobes so the deque never sees a same-side push+pop,
// an overflow or an underflow, and re-times the one-cycle pop latency into
// stall-free output streams (1 word/cycle per side).
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset (also resets the deque upstream)
//   bus  : deque_stream_if.slave, all streams and deque signals
// Side index 0 = front, 1 = back throughout.

// Per-side logic: candidates, same-side arbitration and the output valid reg.
module deque_stream_side (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  logic out_ready,
  input  logic push_ok,     // deque not full
  input  logic pop_ok,      // deque not empty
  input  logic pop_gnt,     // final pop grant for this side
  output logic push_surv,   // push survives same-side arbitration
  output logic pop_surv,    // pop survives same-side arbitration
  output logic out_valid
);
  logic side_turn;          // 0 = push wins next conflict, 1 = pop wins
  logic push_c, pop_c, conflict;

  assign push_c    = in_valid & push_ok;
  // Only pop when the output slot is empty or being drained this cycle.
  assign pop_c     = pop_ok & (~out_valid | out_ready);
  assign conflict  = push_c & pop_c;
  assign push_surv = push_c & ~(conflict & side_turn);
  assign pop_surv  = pop_c & ~(conflict & ~side_turn);

  always_ff @(posedge clk) begin
    if (rst) begin
      side_turn <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (conflict) side_turn <= ~side_turn;
      out_valid <= pop_gnt | (out_valid & ~out_ready);
    end
  end
endmodule

module deque_stream_ctrl #(
  parameter int WORD_WIDTH = 32,
  parameter int MAX_SIZE   = 40,
  parameter int ADDR_WIDTH = $clog2(MAX_SIZE)
) (
  input logic            clk,
  input logic            rst,
  deque_stream_if.slave  bus
);
  localparam logic [ADDR_WIDTH:0] SZ_MAX    = (ADDR_WIDTH+1)'(MAX_SIZE);
  localparam logic [ADDR_WIDTH:0] SZ_MAX_M2 = (ADDR_WIDTH+1)'(MAX_SIZE-2);
  localparam logic [ADDR_WIDTH:0] SZ_ZERO   = '0;
  localparam logic [ADDR_WIDTH:0] SZ_TWO    = (ADDR_WIDTH+1)'(2);

  logic [1:0] in_valid, out_ready, out_valid;
  logic [1:0] push_surv, pop_surv, push_gnt, pop_gnt;
  logic       push_ok, pop_ok;
  logic       push_turn, pop_turn, push_tgl, pop_tgl;

  assign in_valid  = {bus.bin_valid,  bus.fin_valid};
  assign out_ready = {bus.bout_ready, bus.fout_ready};
  assign push_ok   = bus.dq_size < SZ_MAX;
  assign pop_ok    = bus.dq_size > SZ_ZERO;

  for (genvar s = 0; s < 2; s++) begin : g_side
    deque_stream_side u_side (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid[s]),
      .out_ready (out_ready[s]),
      .push_ok   (push_ok),
      .pop_ok    (pop_ok),
      .pop_gnt   (pop_gnt[s]),
      .push_surv (push_surv[s]),
      .pop_surv  (pop_surv[s]),
      .out_valid (out_valid[s])
    );
  end

  // Cross-side limits: with room/content for only one word, the turn bit
  // picks the side; the losing side issues nothing (no backfill).
  always_comb begin
    push_gnt = push_surv;
    pop_gnt  = pop_surv;
    push_tgl = 1'b0;
    pop_tgl  = 1'b0;
    if (&push_surv && bus.dq_size > SZ_MAX_M2) begin
      push_gnt = push_turn ? 2'b10 : 2'b01;
      push_tgl = 1'b1;
    end
    if (&pop_surv && bus.dq_size < SZ_TWO) begin
      pop_gnt = pop_turn ? 2'b10 : 2'b01;
      pop_tgl = 1'b1;
    end
    if (rst) begin
      push_gnt = '0;
      pop_gnt  = '0;
      push_tgl = 1'b0;
      pop_tgl  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      push_turn <= 1'b0;
      pop_turn  <= 1'b0;
    end else begin
      if (push_tgl) push_turn <= ~push_turn;
      if (pop_tgl)  pop_turn  <= ~pop_turn;
    end
  end

  assign bus.dq_front_push      = push_gnt[0];
  assign bus.dq_back_push       = push_gnt[1];
  assign bus.fin_ready          = push_gnt[0];
  assign bus.bin_ready          = push_gnt[1];
  assign bus.dq_front_pop       = pop_gnt[0];
  assign bus.dq_back_pop        = pop_gnt[1];
  assign bus.dq_front_push_data = bus.fin_data;
  assign bus.dq_back_push_data  = bus.bin_data;
  // The deque holds its pop register until the next pop on that side, so
  // passing it through keeps output data stable while stalled.
  assign bus.fout_valid         = out_valid[0];
  assign bus.bout_valid         = out_valid[1];
  assign bus.fout_data          = bus.dq_front_pop_data;
  assign bus.bout_data          = bus.dq_back_pop_data;
endmodule

// File: tb/tb_deque_stream_ctrl.sv
// Bench for deque_stream_ctrl: directed scenarios with literal expectations,
// then random open-loop stimulus (arbitrary occupancy) and closed-loop
// stimulus against a queue acting as the deque. A behavioural model checks
// strobes, readies, valids and data every cycle.
module tb_deque_stream_ctrl;
  localparam int WW  = 32;
  localparam int MAX = 40;
  localparam int AW  = $clog2(MAX);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  deque_stream_if #(.WORD_WIDTH(WW), .ADDR_WIDTH(AW)) bus ();

  deque_stream_ctrl #(.WORD_WIDTH(WW), .MAX_SIZE(MAX), .ADDR_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit       m_init = 0;
  bit [1:0] m_st;          // per-side "pop wins next conflict"
  bit       m_pt, m_ot;    // push / pop cross-side turn (0 = front)
  bit [1:0] m_ov;          // words waiting on each output stream
  bit       closed = 0;
  bit [1:0] prev_hold;
  logic [WW-1:0] prev_fd, prev_bd;
  // strobes captured mid-cycle for the closed-loop deque
  bit s_fpush, s_bpush, s_fpop, s_bpop;
  logic [WW-1:0] s_fdata, s_bdata;

  always @(negedge clk) begin
    #2;
    s_fpush = bus.dq_front_push; s_bpush = bus.dq_back_push;
    s_fpop  = bus.dq_front_pop;  s_bpop  = bus.dq_back_pop;
    s_fdata = bus.fin_data;      s_bdata = bus.bin_data;
    if (rst) begin
      chk("rst_strobes", {bus.dq_front_push, bus.dq_back_push, bus.dq_front_pop,
                          bus.dq_back_pop, bus.fin_ready, bus.bin_ready}, 6'b0);
      m_st = '0; m_pt = 0; m_ot = 0; m_ov = '0; m_init = 1; prev_hold = '0;
    end else if (m_init) begin
      int sz;
      bit [1:0] iv, rd, wp, wo, st_n;
      sz = int'(bus.dq_size);
      iv = {bus.bin_valid, bus.fin_valid};
      rd = {bus.bout_ready, bus.fout_ready};
      st_n = m_st;
      for (int s = 0; s < 2; s++) begin
        wp[s] = iv[s] && (sz < MAX);
        wo[s] = (sz > 0) && (!m_ov[s] || rd[s]);
        if (wp[s] && wo[s]) begin
          if (m_st[s]) wp[s] = 0; else wo[s] = 0;
          st_n[s] = !m_st[s];
        end
      end
      if (wp == 2'b11 && (MAX - sz) < 2) begin
        wp = m_pt ? 2'b10 : 2'b01;
        m_pt = !m_pt;
      end
      if (wo == 2'b11 && sz < 2) begin
        wo = m_ot ? 2'b10 : 2'b01;
        m_ot = !m_ot;
      end
      chk("front_push",  bus.dq_front_push, wp[0]);
      chk("back_push",   bus.dq_back_push,  wp[1]);
      chk("fin_ready",   bus.fin_ready,     wp[0]);
      chk("bin_ready",   bus.bin_ready,     wp[1]);
      chk("front_pop",   bus.dq_front_pop,  wo[0]);
      chk("back_pop",    bus.dq_back_pop,   wo[1]);
      chk("fout_valid",  bus.fout_valid,    m_ov[0]);
      chk("bout_valid",  bus.bout_valid,    m_ov[1]);
      chk("fpush_data",  bus.dq_front_push_data, bus.fin_data);
      chk("bpush_data",  bus.dq_back_push_data,  bus.bin_data);
      if (m_ov[0]) chk("fout_data", bus.fout_data, bus.dq_front_pop_data);
      if (m_ov[1]) chk("bout_data", bus.bout_data, bus.dq_back_pop_data);
      if (closed && prev_hold[0]) chk("fout_hold", bus.fout_data, prev_fd);
      if (closed && prev_hold[1]) chk("bout_hold", bus.bout_data, prev_bd);
      prev_hold = m_ov & ~rd;
      prev_fd = bus.fout_data;
      prev_bd = bus.bout_data;
      for (int s = 0; s < 2; s++) m_ov[s] = wo[s] || (m_ov[s] && !rd[s]);
      m_st = st_n;
    end
  end

  // ---------------- closed-loop deque ----------------
  logic [WW-1:0] q[$];
  logic [WW-1:0] cl_f = '0, cl_b = '0;

  always @(posedge clk) begin
    if (closed) begin
      if (rst) begin
        q.delete();
        cl_f <= '0;
        cl_b <= '0;
      end else begin
        if (s_fpop || s_bpop)
          chk("no_underflow", (q.size() >= (int'(s_fpop) + int'(s_bpop))) ? 1 : 0, 1);
        if (s_fpop && q.size() > 0) cl_f <= q.pop_front();
        if (s_bpop && q.size() > 0) cl_b <= q.pop_back();
        if (s_fpush || s_bpush)
          chk("no_overflow", (q.size() + int'(s_fpush) + int'(s_bpush) <= MAX) ? 1 : 0, 1);
        if (s_fpush) q.push_front(s_fdata);
        if (s_bpush) q.push_back(s_bdata);
      end
    end
  end

  task automatic set_in(input bit fv, input bit bv, input bit fr, input bit br, input int sz);
    bus.fin_valid  = fv;
    bus.bin_valid  = bv;
    bus.fout_ready = fr;
    bus.bout_ready = br;
    bus.dq_size    = (AW+1)'(sz);
  endtask

  task automatic rand_sz(output int sz);
    case ($urandom_range(0, 7))
      0: sz = 0;
      1: sz = 1;
      2: sz = 2;
      3: sz = MAX - 2;
      4: sz = MAX - 1;
      5: sz = MAX;
      default: sz = $urandom_range(0, MAX);
    endcase
  endtask

  initial begin
    int sz;
    bus.fin_data = '0; bus.bin_data = '0;
    bus.dq_front_pop_data = '0; bus.dq_back_pop_data = '0;
    set_in(0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);

    // empty deque: no pops, outputs stay idle
    rst = 0;
    set_in(0, 0, 1, 1, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t1_fpop", bus.dq_front_pop, 0);
      chk("t1_bpop", bus.dq_back_pop, 0);
      chk("t1_fout_valid", bus.fout_valid, 0);
      @(negedge clk);
    end

    // same-side push/pop alternate starting with push
    set_in(1, 0, 1, 1, 5);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t2_fpush", bus.dq_front_push, (i % 2 == 0) ? 1 : 0);
      chk("t2_fpop",  bus.dq_front_pop,  (i % 2 == 1) ? 1 : 0);
      @(negedge clk);
    end

    // one slot left: push_turn alternates; two slots: both
    set_in(1, 1, 0, 0, MAX - 1);
    #1; chk("t3a_fpush", bus.dq_front_push, 1); chk("t3a_bpush", bus.dq_back_push, 0);
    @(negedge clk);
    #1; chk("t3b_fpush", bus.dq_front_push, 0); chk("t3b_bpush", bus.dq_back_push, 1);
    @(negedge clk);
    set_in(1, 1, 0, 0, MAX - 2);
    #1; chk("t3c_fpush", bus.dq_front_push, 1); chk("t3c_bpush", bus.dq_back_push, 1);
    @(negedge clk);

    // one word left: front pop only, then it appears on fout
    set_in(0, 0, 1, 1, 1);
    bus.dq_front_pop_data = 32'hCAFE_0001;
    #1; chk("t4a_fpop", bus.dq_front_pop, 1); chk("t4a_bpop", bus.dq_back_pop, 0);
    @(negedge clk);
    set_in(0, 0, 1, 1, 0);
    #1;
    chk("t4b_fpop", bus.dq_front_pop, 0); chk("t4b_bpop", bus.dq_back_pop, 0);
    chk("t4b_fout_valid", bus.fout_valid, 1);
    chk("t4b_fout_data", bus.fout_data, 32'hCAFE_0001);
    @(negedge clk);

    // back pop streaming at full rate, then stall
    for (int k = 1; k <= 8; k++) begin
      set_in(0, 0, 1, 1, 20);
      bus.dq_back_pop_data = 32'hB000_0000 + k;
      #1;
      chk("t5_bpop", bus.dq_back_pop, 1);
      chk("t5_bout_valid", bus.bout_valid, (k > 1) ? 1 : 0);
      @(negedge clk);
    end
    set_in(0, 0, 0, 0, 20);
    bus.dq_back_pop_data = 32'hB000_0009;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("t5_stall_bpop", bus.dq_back_pop, 0);
      chk("t5_stall_bvalid", bus.bout_valid, 1);
      chk("t5_stall_bdata", bus.bout_data, 32'hB000_0009);
      @(negedge clk);
    end

    // push_turn -> 1, then reset with words in flight
    set_in(1, 1, 0, 0, MAX - 1);
    #1; chk("t6a_fpush", bus.dq_front_push, 1); chk("t6a_fvalid", bus.fout_valid, 1);
    @(negedge clk);
    rst = 1;
    #1; chk("t6b_strobes", {bus.dq_front_push, bus.dq_back_push, bus.dq_front_pop, bus.dq_back_pop}, 4'b0);
    @(negedge clk);
    rst = 0;
    #1;
    chk("t6c_fvalid", bus.fout_valid, 0);
    chk("t6c_bvalid", bus.bout_valid, 0);
    chk("t6c_strobes", {bus.dq_front_push, bus.dq_back_push, bus.dq_front_pop, bus.dq_back_pop}, 4'b1000);
    @(negedge clk);

    // random open loop
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      rand_sz(sz);
      set_in($urandom_range(0, 1), $urandom_range(0, 1),
             $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, sz);
      bus.fin_data = $urandom; bus.bin_data = $urandom;
      bus.dq_front_pop_data = $urandom; bus.dq_back_pop_data = $urandom;
      @(negedge clk);
    end

    // random closed loop against a queue deque
    rst = 1;
    closed = 1;
    set_in(0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 499) == 0);
      set_in($urandom_range(0, 9) < ((c / 500) % 2 ? 3 : 8),
             $urandom_range(0, 9) < ((c / 500) % 2 ? 3 : 8),
             $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7, q.size());
      bus.fin_data = $urandom; bus.bin_data = $urandom;
      bus.dq_front_pop_data = cl_f; bus.dq_back_pop_data = cl_b;
      @(negedge clk);
    end

    #5;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
